hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the decode stage.
- Keeps a per-register scoreboard of in-flight writebacks and decides each cycle whether the decoded instruction issues to EX or stalls in ID.
- On a taken branch or jump from EX, it runs a fixed-length flush sequence.
- Sits beside the decode stage and drives the IF/ID and ID/EX stall and flush controls.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_ctrl_reg_scoreboard.sv | 47 ++++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-stage hazard controller.
//   ctrl_state_t : FSM state encoding (RUN=0, FLUSH=1)
//   LAT_W        : scoreboard counter width for the default LAT_MAX of 4
//   clamp_lat    : maps a raw writeback latency into the range 1..lat_max
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1
    } ctrl_state_t;

    localparam int LAT_MAX_DEF = 4;
    localparam int LAT_W       = $clog2(LAT_MAX_DEF + 1);

    // A zero latency would never mark the register busy, so it is promoted to 1.
    function automatic int unsigned clamp_lat(input logic [2:0] lat,
                                              input int unsigned lat_max);
        int unsigned l;
        l = {29'd0, lat};
        if (l == 0) begin
            return 1;
        end else if (l > lat_max) begin
            return lat_max;
        end else begin
            return l;
        end
    endfunction

endpackage

// File: rtl/hazard_ctrl_reg_scoreboard.sv
// Per-register scoreboard of in-flight writebacks.
//   clk, rst   : clock and synchronous active-low reset
//   set_en     : load counter[set_idx] with set_lat this edge
//   set_idx    : destination register index
//   set_lat    : already-clamped latency (1..LAT_MAX)
//   busy_mask  : bit r high while counter[r] is nonzero; bit 0 always low
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int LAT_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set_en,
    input  logic [$clog2(NUM_REGS)-1:0]   set_idx,
    input  logic [$clog2(LAT_MAX+1)-1:0]  set_lat,
    output logic [NUM_REGS-1:0]           busy_mask
);

    localparam int CW = $clog2(LAT_MAX + 1);
    localparam int IW = $clog2(NUM_REGS);

    logic [CW-1:0] cnt [NUM_REGS];

    // Issue of a register that is still counting is blocked by the WAW check,
    // so the load branch never competes with a live decrement.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!rst || r == 0) begin
                cnt[r] <= '0;
            end else if (set_en && set_idx == IW'(r)) begin
                cnt[r] <= set_lat;
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencing controller: RAW/WAW scoreboard stalls and
// fixed-length flush after an EX redirect.
//   clk, rst            : clock and synchronous active-low reset
//   id_*                : decoded instruction fields in ID
//   ex_redirect         : taken branch/jump resolved in EX
//   id_issue            : ID instruction moves to EX this edge
//   id_stall, if_stall  : hold ID, and hold PC plus IF/ID
//   flush_if_id/_id_ex  : squash IF/ID, bubble ID/EX
//   busy_mask           : registers with a pending writeback
//   ctrl_state          : registered FSM state
//   stall_cnt           : saturating count of stall cycles
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal issue/stall decisions
// FLUSH | squashing the wrong path; lasts FLUSH_CYCLES, restarts on redirect
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int LAT_MAX      = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [4:0]          id_rs1_idx,
    input  logic [4:0]          id_rs2_idx,
    input  logic [4:0]          id_rd_idx,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic                id_writes_rd,
    input  logic [2:0]          id_wb_lat,
    input  logic                ex_redirect,
    output logic                id_issue,
    output logic                id_stall,
    output logic                if_stall,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [1:0]          ctrl_state,
    output logic [31:0]         stall_cnt
);

    localparam int CW = $clog2(LAT_MAX + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    ctrl_state_t   state_q, state_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;

    logic [NUM_REGS-1:0] busy_raw;
    logic                hz;
    logic                in_run;
    logic                issue_raw;
    logic                stall_raw;
    logic                flush_raw;
    logic                set_en;
    logic [CW-1:0]       set_lat;
    logic [31:0]         stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (ex_redirect) begin
                    flush_cnt_d = FW'(FLUSH_CYCLES - 1);
                end else if (flush_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    // The rd term is the WAW check; it also keeps scoreboard loads collision-free.
    always_comb begin
        hz = (id_uses_rs1  && id_rs1_idx != 5'd0 && busy_raw[id_rs1_idx]) ||
             (id_uses_rs2  && id_rs2_idx != 5'd0 && busy_raw[id_rs2_idx]) ||
             (id_writes_rd && id_rd_idx  != 5'd0 && busy_raw[id_rd_idx]);
    end

    assign in_run    = (state_q == RUN);
    assign issue_raw = in_run && id_valid && !hz && !ex_redirect;
    assign stall_raw = in_run && id_valid &&  hz && !ex_redirect;
    // Redirect reaches the flush outputs combinationally for a zero-cycle response.
    assign flush_raw = ex_redirect || (state_q == FLUSH);

    assign set_en  = issue_raw && id_writes_rd && (id_rd_idx != 5'd0);
    assign set_lat = CW'(clamp_lat(id_wb_lat, LAT_MAX));

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .LAT_MAX  (LAT_MAX)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_en),
        .set_idx   (id_rd_idx),
        .set_lat   (set_lat),
        .busy_mask (busy_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_raw && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    // Everything reads as zero while reset is held, before and after the first edge.
    assign id_issue    = rst && issue_raw;
    assign id_stall    = rst && stall_raw;
    assign if_stall    = rst && stall_raw;
    assign flush_if_id = rst && flush_raw;
    assign flush_id_ex = rst && flush_raw;
    assign busy_mask   = rst ? busy_raw : '0;
    assign ctrl_state  = rst ? state_q : 2'd0;
    assign stall_cnt   = rst ? stall_cnt_q : 32'd0;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_idx;
    logic [4:0]  id_rs2_idx;
    logic [4:0]  id_rd_idx;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_writes_rd;
    logic [2:0]  id_wb_lat;
    logic        ex_redirect;
    logic        id_issue;
    logic        id_stall;
    logic        if_stall;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] busy_mask;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(
        .NUM_REGS     (32),
        .LAT_MAX      (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1_idx   (id_rs1_idx),
        .id_rs2_idx   (id_rs2_idx),
        .id_rd_idx    (id_rd_idx),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_writes_rd (id_writes_rd),
        .id_wb_lat    (id_wb_lat),
        .ex_redirect  (ex_redirect),
        .id_issue     (id_issue),
        .id_stall     (id_stall),
        .if_stall     (if_stall),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .busy_mask    (busy_mask),
        .ctrl_state   (ctrl_state),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let inputs be set away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_idx = 0; id_rs2_idx = 0; id_rd_idx = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_writes_rd = 0; id_wb_lat = 0;
        ex_redirect = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rd,
                         input logic wr, input logic [2:0] lat);
        id_valid = 1; id_rs1_idx = rs1; id_uses_rs1 = u1;
        id_rs2_idx = 0; id_uses_rs2 = 0;
        id_rd_idx = rd; id_writes_rd = wr; id_wb_lat = lat;
        ex_redirect = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_issue"}, {63'd0, id_issue}, 64'd0);
        chk({tag, "_stall"}, {63'd0, id_stall}, 64'd0);
        chk({tag, "_ifstall"}, {63'd0, if_stall}, 64'd0);
        chk({tag, "_flush"}, {62'd0, flush_if_id, flush_id_ex}, 64'd0);
        chk({tag, "_busy"}, {32'd0, busy_mask}, 64'd0);
        chk({tag, "_state"}, {62'd0, ctrl_state}, 64'd0);
        chk({tag, "_scnt"}, {32'd0, stall_cnt}, 64'd0);
    endtask

    initial begin
        // Reset held for 3 cycles with redirect and a valid instruction present.
        rst = 0;
        idle();
        id_valid = 1; ex_redirect = 1;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk_all_zero("rst_hold");
            tick();
        end
        rst = 1;
        idle();
        settle();
        chk_all_zero("rst_rel");

        // RAW: rd=5 lat=3 then rs1=5 consumer -> 3 stalls, issue on 4th.
        tick();
        instr(5'd0, 0, 5'd5, 1, 3'd3);
        settle();
        chk("raw_prod_issue", {63'd0, id_issue}, 64'd1);
        tick();
        instr(5'd5, 1, 5'd0, 0, 3'd0);
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("raw_stall", {61'd0, id_stall, if_stall, id_issue}, 64'b110);
            chk("raw_busy", {32'd0, busy_mask}, 64'h20);
            tick();
            settle();
        end
        chk("raw_issue", {62'd0, id_stall, id_issue}, 64'b01);
        chk("raw_busy_clr", {32'd0, busy_mask}, 64'd0);
        chk("raw_scnt", {32'd0, stall_cnt}, 64'd3);

        // x0 destination never marks busy; x0 source never stalls.
        tick();
        instr(5'd0, 0, 5'd0, 1, 3'd3);
        settle();
        chk("x0_wr_issue", {63'd0, id_issue}, 64'd1);
        tick();
        instr(5'd0, 1, 5'd0, 0, 3'd0);
        settle();
        chk("x0_busy", {32'd0, busy_mask}, 64'd0);
        chk("x0_rs_issue", {62'd0, id_stall, id_issue}, 64'b01);

        // lat=0 clamps to 1.
        tick();
        instr(5'd0, 0, 5'd7, 1, 3'd0);
        settle();
        chk("lat0_issue", {63'd0, id_issue}, 64'd1);
        tick();
        idle();
        settle();
        chk("lat0_busy", {32'd0, busy_mask}, 64'h80);
        tick();
        settle();
        chk("lat0_clr", {32'd0, busy_mask}, 64'd0);

        // lat=7 clamps to LAT_MAX=4.
        instr(5'd0, 0, 5'd9, 1, 3'd7);
        settle();
        chk("lat7_issue", {63'd0, id_issue}, 64'd1);
        tick();
        idle();
        settle();
        for (int i = 0; i < 4; i++) begin
            chk("lat7_busy", {32'd0, busy_mask}, 64'h200);
            tick();
            settle();
        end
        chk("lat7_clr", {32'd0, busy_mask}, 64'd0);

        // WAW: rd=3 lat=4, then rd=3 lat=1 stalls 4 cycles.
        instr(5'd0, 0, 5'd3, 1, 3'd4);
        settle();
        chk("waw_first_issue", {63'd0, id_issue}, 64'd1);
        tick();
        instr(5'd0, 0, 5'd3, 1, 3'd1);
        settle();
        for (int i = 0; i < 4; i++) begin
            chk("waw_stall", {62'd0, id_stall, id_issue}, 64'b10);
            tick();
            settle();
        end
        chk("waw_issue", {62'd0, id_stall, id_issue}, 64'b01);
        tick();
        idle();
        settle();
        chk("waw_rebusy", {32'd0, busy_mask}, 64'h8);
        chk("waw_scnt", {32'd0, stall_cnt}, 64'd7);
        tick();
        settle();
        chk("waw_clr", {32'd0, busy_mask}, 64'd0);

        // Redirect with a pending writeback on x6 (lat 4).
        instr(5'd0, 0, 5'd6, 1, 3'd4);
        settle();
        chk("rd_pre_issue", {63'd0, id_issue}, 64'd1);
        tick();
        instr(5'd1, 1, 5'd0, 0, 3'd0);
        ex_redirect = 1;
        settle();
        chk("rd_c0_flush", {61'd0, flush_if_id, flush_id_ex, id_issue}, 64'b110);
        chk("rd_c0_stall", {63'd0, id_stall}, 64'd0);
        chk("rd_c0_busy", {32'd0, busy_mask}, 64'h40);
        tick();
        ex_redirect = 0;
        settle();
        chk("rd_c1_flush", {61'd0, flush_if_id, flush_id_ex, id_issue}, 64'b110);
        chk("rd_c1_state", {62'd0, ctrl_state}, 64'd1);
        chk("rd_c1_busy", {32'd0, busy_mask}, 64'h40);
        tick();
        settle();
        chk("rd_c2_flush", {61'd0, flush_if_id, flush_id_ex, id_issue}, 64'b110);
        chk("rd_c2_state", {62'd0, ctrl_state}, 64'd1);
        tick();
        settle();
        chk("rd_c3_run", {62'd0, ctrl_state}, 64'd0);
        chk("rd_c3_issue", {61'd0, flush_if_id, flush_id_ex, id_issue}, 64'b001);
        chk("rd_c3_busy", {32'd0, busy_mask}, 64'h40);
        tick();
        idle();
        settle();
        chk("rd_c4_busy", {32'd0, busy_mask}, 64'd0);

        // Back-to-back redirect: second redirect in FLUSH cycle 1.
        ex_redirect = 1;
        settle();
        chk("bb_c0_flush", {62'd0, flush_if_id, flush_id_ex}, 64'b11);
        tick();
        settle();
        chk("bb_c1_state", {62'd0, ctrl_state}, 64'd1);
        tick();
        ex_redirect = 0;
        settle();
        chk("bb_c2_flush", {62'd0, flush_if_id, flush_id_ex}, 64'b11);
        chk("bb_c2_state", {62'd0, ctrl_state}, 64'd1);
        tick();
        settle();
        chk("bb_c3_flush", {62'd0, flush_if_id, flush_id_ex}, 64'b11);
        tick();
        settle();
        chk("bb_c4_run", {64'd0, ctrl_state, flush_if_id, flush_id_ex}, 64'd0);

        // Reset pulse mid-flush, with a pending writeback on x10.
        instr(5'd0, 0, 5'd10, 1, 3'd4);
        settle();
        chk("mr_issue", {63'd0, id_issue}, 64'd1);
        tick();
        idle();
        ex_redirect = 1;
        settle();
        tick();
        ex_redirect = 0;
        settle();
        chk("mr_in_flush", {62'd0, ctrl_state}, 64'd1);
        rst = 0;
        settle();
        chk_all_zero("mr_rst");
        tick();
        rst = 1;
        settle();
        chk_all_zero("mr_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
